// File: rtl/sdram_access_arbiter.sv
// Two-requester (CPU word R/W, video burst read) arbiter in front of KFSDRAM.
// Optional video starvation guard: define SDRAM_ARB_STARVE_GUARD_EN.
module sdram_access_arbiter #(
  parameter int ADDR_WIDTH     = 25,
  parameter int NUM_WIDTH      = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int CPU_STREAK_MAX = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  cpu_ack,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_address,
  input  logic [NUM_WIDTH-1:0]  vid_num,
  output logic [DATA_WIDTH-1:0] vid_data_out,
  output logic                  vid_data_valid,
  output logic                  vid_done,
  output logic [ADDR_WIDTH-1:0] access_address,
  output logic [NUM_WIDTH-1:0]  access_num,
  output logic [DATA_WIDTH-1:0] access_data_in,
  input  logic [DATA_WIDTH-1:0] access_data_out,
  output logic                  write_request,
  output logic                  read_request,
  input  logic                  write_flag,
  input  logic                  read_flag,
  input  logic                  idle
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_XFER,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_VID
  } owner_t;

  if (CPU_STREAK_MAX < 1) begin : g_cfg_check
    $error("CPU_STREAK_MAX must be at least 1");
  end

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_WIDTH-1:0]  num_q, num_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  is_wr_q, is_wr_d;
  logic                  wreq_q, wreq_d;
  logic                  rreq_q, rreq_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] vid_rdata_q, vid_rdata_d;
  logic                  vid_valid_q, vid_valid_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic                  vid_done_q, vid_done_d;

  logic                  grant_cpu;
  logic                  grant_vid;
  logic                  vid_turn;
  logic                  any_flag;
  logic [NUM_WIDTH-1:0]  vid_num_fix;

  assign any_flag    = write_flag | read_flag;
  assign vid_num_fix = (vid_num == '0) ? NUM_WIDTH'(1) : vid_num;

`ifdef SDRAM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(CPU_STREAK_MAX + 1);

  logic [SW-1:0] streak_q, streak_d;

  assign vid_turn = (streak_q == SW'(CPU_STREAK_MAX));

  // Counts CPU wins only while video is actually waiting.
  always_comb begin
    streak_d = streak_q;
    if (!vid_req) begin
      streak_d = '0;
    end else if (grant_vid) begin
      streak_d = '0;
    end else if (grant_cpu) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign vid_turn = 1'b0;
`endif

  always_comb begin
    grant_cpu = 1'b0;
    grant_vid = 1'b0;
    if (state_q == S_IDLE && idle) begin
      if (cpu_req && !(vid_req && vid_turn)) begin
        grant_cpu = 1'b1;
      end else if (vid_req) begin
        grant_vid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    num_d       = num_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    wreq_d      = wreq_q;
    rreq_d      = rreq_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    vid_valid_d = 1'b0;
    cpu_ack_d   = 1'b0;
    vid_done_d  = 1'b0;

    // Read words may arrive on the same cycle the flag first rises.
    if ((state_q == S_ISSUE || state_q == S_XFER) && read_flag && !is_wr_q) begin
      if (owner_q == OWN_CPU) begin
        cpu_rdata_d = access_data_out;
      end else if (owner_q == OWN_VID) begin
        vid_rdata_d = access_data_out;
        vid_valid_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (grant_cpu) begin
          state_d = S_ISSUE;
          owner_d = OWN_CPU;
          addr_d  = cpu_address;
          num_d   = NUM_WIDTH'(1);
          wdata_d = cpu_write ? cpu_data_in : '0;
          is_wr_d = cpu_write;
          wreq_d  = cpu_write;
          rreq_d  = !cpu_write;
        end else if (grant_vid) begin
          state_d = S_ISSUE;
          owner_d = OWN_VID;
          addr_d  = vid_address;
          num_d   = vid_num_fix;
          wdata_d = '0;
          is_wr_d = 1'b0;
          wreq_d  = 1'b0;
          rreq_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (any_flag) begin
          state_d = S_XFER;
          wreq_d  = 1'b0;
          rreq_d  = 1'b0;
        end
      end
      S_XFER: begin
        if (!any_flag) begin
          state_d    = S_DONE;
          cpu_ack_d  = (owner_q == OWN_CPU);
          vid_done_d = (owner_q == OWN_VID);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
        addr_d  = '0;
        num_d   = '0;
        wdata_d = '0;
        is_wr_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      addr_q      <= '0;
      num_q       <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      wreq_q      <= 1'b0;
      rreq_q      <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      vid_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      num_q       <= num_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      wreq_q      <= wreq_d;
      rreq_q      <= rreq_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      vid_valid_q <= vid_valid_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_done_q  <= vid_done_d;
    end
  end

  assign access_address = addr_q;
  assign access_num     = num_q;
  assign access_data_in = wdata_q;
  assign write_request  = wreq_q;
  assign read_request   = rreq_q;
  assign cpu_data_out   = cpu_rdata_q;
  assign cpu_ack        = cpu_ack_q;
  assign vid_data_out   = vid_rdata_q;
  assign vid_data_valid = vid_valid_q;
  assign vid_done       = vid_done_q;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Directed bench for sdram_access_arbiter with a small KFSDRAM model.
// Guard expectations follow SDRAM_ARB_STARVE_GUARD_EN.
module tb_sdram_access_arbiter;
  localparam int AW = 25;
  localparam int NW = 10;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_write;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_data_in, cpu_data_out;
  logic          cpu_ack;
  logic          vid_req;
  logic [AW-1:0] vid_address;
  logic [NW-1:0] vid_num;
  logic [DW-1:0] vid_data_out;
  logic          vid_data_valid, vid_done;
  logic [AW-1:0] access_address;
  logic [NW-1:0] access_num;
  logic [DW-1:0] access_data_in, access_data_out;
  logic          write_request, read_request;
  logic          write_flag, read_flag, idle;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sdram_access_arbiter #(
    .ADDR_WIDTH(AW), .NUM_WIDTH(NW), .DATA_WIDTH(DW), .CPU_STREAK_MAX(4)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_data_out(cpu_data_out), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_address(vid_address), .vid_num(vid_num),
    .vid_data_out(vid_data_out), .vid_data_valid(vid_data_valid),
    .vid_done(vid_done),
    .access_address(access_address), .access_num(access_num),
    .access_data_in(access_data_in), .access_data_out(access_data_out),
    .write_request(write_request), .read_request(read_request),
    .write_flag(write_flag), .read_flag(read_flag), .idle(idle)
  );

  // KFSDRAM model: 2-cycle latency, then access_num flag cycles, then idle.
  typedef enum logic [1:0] {M_IDLE, M_WAIT, M_FLAG, M_REC} mst_t;
  mst_t          mst;
  logic          m_rd;
  logic [NW:0]   m_left;
  logic [NW-1:0] m_idx;
  logic [1:0]    m_wait;
  logic [DW-1:0] rd_base;
  logic [DW-1:0] m_wdata;
  logic [AW-1:0] m_waddr;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mst <= M_IDLE; idle <= 1'b1;
      read_flag <= 1'b0; write_flag <= 1'b0;
      access_data_out <= '0; m_rd <= 1'b0;
      m_left <= '0; m_idx <= '0; m_wait <= '0;
      m_wdata <= '0; m_waddr <= '0;
    end else begin
      case (mst)
        M_IDLE: if (read_request || write_request) begin
          idle <= 1'b0; m_rd <= read_request;
          m_left <= (access_num == '0) ? (NW+1)'(1) : {1'b0, access_num};
          m_idx <= '0; m_wait <= 2'd2; mst <= M_WAIT;
        end
        M_WAIT: if (m_wait != 2'd1) m_wait <= m_wait - 2'd1;
        else begin
          mst <= M_FLAG; m_left <= m_left - 1'b1; m_idx <= m_idx + 1'b1;
          if (m_rd) begin
            read_flag <= 1'b1;
            access_data_out <= rd_base + DW'(m_idx);
          end else begin
            write_flag <= 1'b1;
            m_wdata <= access_data_in; m_waddr <= access_address;
          end
        end
        M_FLAG: if (m_left == '0) begin
          read_flag <= 1'b0; write_flag <= 1'b0; mst <= M_REC;
        end else begin
          m_left <= m_left - 1'b1; m_idx <= m_idx + 1'b1;
          access_data_out <= rd_base + DW'(m_idx);
        end
        M_REC: begin idle <= 1'b1; mst <= M_IDLE; end
        default: mst <= M_IDLE;
      endcase
    end
  end

  function automatic bit outs_zero();
    return cpu_data_out == '0 && cpu_ack == 1'b0 && vid_data_out == '0
        && vid_data_valid == 1'b0 && vid_done == 1'b0
        && access_address == '0 && access_num == '0
        && access_data_in == '0 && write_request == 1'b0
        && read_request == 1'b0;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_req = 0; cpu_write = 0; cpu_address = '0;
    cpu_data_in = '0; vid_req = 0; vid_address = '0; vid_num = '0;
    rd_base = '0;
    tick(); tick();
    checks++;
    if (outs_zero() !== 1'b1) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, need all 0");
    end
    reset = 1'b0;
    tick();
    checks++;
    if (outs_zero() !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: got nonzero outputs, need all 0");
    end
  endtask

  task automatic test_cpu_write();
    int n; bit held;
    cpu_write = 1; cpu_address = 25'h00123; cpu_data_in = 16'h00A5; cpu_req = 1;
    tick();
    checks++;
    if (write_request !== 1'b1 || read_request !== 1'b0) begin
      errors++;
      $display("FAIL wr_issue: wr=%b rd=%b, need wr=1 rd=0", write_request, read_request);
    end
    checks++;
    if (access_address !== 25'h00123 || access_num !== 10'd1 || access_data_in !== 16'h00A5) begin
      errors++;
      $display("FAIL wr_fields: addr=%h num=%0d din=%h, need 00123 1 00a5",
               access_address, access_num, access_data_in);
    end
    held = 1; n = 0;
    while (write_flag !== 1'b1 && n < 20) begin
      if (write_request !== 1'b1) held = 0;
      tick(); n++;
    end
    checks++;
    if (write_flag !== 1'b1 || !held) begin
      errors++; $display("FAIL wr_hold: flag=%b held=%0d, need 1 1", write_flag, held);
    end
    tick();
    checks++;
    if (write_request !== 1'b0) begin
      errors++; $display("FAIL wr_drop: got %b need 0", write_request);
    end
    n = 0;
    while (cpu_ack !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (cpu_ack !== 1'b1 || write_flag !== 1'b0) begin
      errors++; $display("FAIL wr_ack: ack=%b flag=%b, need 1 0", cpu_ack, write_flag);
    end
    cpu_req = 0;
    tick();
    checks++;
    if (cpu_ack !== 1'b0 || access_address !== '0) begin
      errors++;
      $display("FAIL wr_ack_pulse: ack=%b addr=%h, need 0 0", cpu_ack, access_address);
    end
    checks++;
    if (m_wdata !== 16'h00A5 || m_waddr !== 25'h00123) begin
      errors++;
      $display("FAIL wr_data_mem: data=%h addr=%h, need 00a5 00123", m_wdata, m_waddr);
    end
    tick(); tick();
  endtask

  task automatic test_cpu_read();
    int n;
    cpu_write = 0; cpu_address = 25'h00200; rd_base = 16'h005A; cpu_req = 1;
    tick();
    checks++;
    if (read_request !== 1'b1 || access_num !== 10'd1) begin
      errors++;
      $display("FAIL rd_issue: rd=%b num=%0d, need 1 1", read_request, access_num);
    end
    n = 0;
    while (cpu_ack !== 1'b1 && n < 30) begin tick(); n++; end
    checks++;
    if (cpu_ack !== 1'b1 || cpu_data_out !== 16'h005A) begin
      errors++;
      $display("FAIL rd_data: ack=%b data=%h, need 1 005a", cpu_ack, cpu_data_out);
    end
    cpu_req = 0;
    tick();
    checks++;
    if (cpu_data_out !== 16'h005A) begin
      errors++; $display("FAIL rd_hold: got %h need 005a", cpu_data_out);
    end
    tick(); tick();
  endtask

  task automatic test_video(input logic [NW-1:0] num, input int exp_words);
    int n, cnt, bad, dn;
    vid_address = 25'h40000; vid_num = num; rd_base = 16'h1000; vid_req = 1;
    tick();
    checks++;
    if (read_request !== 1'b1 || access_num !== NW'(exp_words)
        || access_address !== 25'h40000) begin
      errors++;
      $display("FAIL vid_issue: rd=%b num=%0d addr=%h, need 1 %0d 40000",
               read_request, access_num, access_address, exp_words);
    end
    cnt = 0; bad = 0; dn = 0; n = 0;
    while (dn == 0 && n < 100) begin
      tick(); n++;
      if (vid_data_valid === 1'b1) begin
        if (vid_data_out !== 16'h1000 + DW'(cnt)) bad++;
        cnt++;
      end
      if (vid_done === 1'b1) begin dn++; vid_req = 0; end
    end
    checks++;
    if (dn != 1 || cnt != exp_words || bad != 0) begin
      errors++;
      $display("FAIL vid_burst: done=%0d words=%0d bad=%0d, need 1 %0d 0",
               dn, cnt, bad, exp_words);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (vid_done === 1'b1 || vid_data_valid === 1'b1) dn++;
    end
    checks++;
    if (dn != 1) begin
      errors++; $display("FAIL vid_done_once: done=%0d need 1", dn);
    end
  endtask

  task automatic test_both();
    int n, cnt, dn, overlap, order;
    bit cpu_fin;
    cpu_write = 1; cpu_address = 25'h00300; cpu_data_in = 16'h1234;
    vid_address = 25'h40010; vid_num = 10'd4; rd_base = 16'h1000;
    cpu_req = 1; vid_req = 1;
    tick();
    checks++;
    if (write_request !== 1'b1 || read_request !== 1'b0) begin
      errors++;
      $display("FAIL both_cpu_first: wr=%b rd=%b, need 1 0", write_request, read_request);
    end
    cnt = 0; dn = 0; overlap = 0; order = 0; cpu_fin = 0; n = 0;
    while (dn == 0 && n < 200) begin
      tick(); n++;
      if (write_request === 1'b1 && read_request === 1'b1) overlap++;
      if (read_request === 1'b1 && !cpu_fin) order++;
      if (cpu_ack === 1'b1) begin cpu_fin = 1; cpu_req = 0; end
      if (vid_data_valid === 1'b1) cnt++;
      if (vid_done === 1'b1) begin dn++; vid_req = 0; end
    end
    checks++;
    if (overlap != 0 || order != 0 || !cpu_fin || dn != 1 || cnt != 4) begin
      errors++;
      $display("FAIL both_sequence: ovl=%0d early=%0d cpu=%0d done=%0d words=%0d, need 0 0 1 1 4",
               overlap, order, cpu_fin, dn, cnt);
    end
    tick(); tick();
  endtask

  task automatic test_guard();
    int n, g;
    logic prev, cur;
    logic [5:0] gv, exp_gv;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    exp_gv = 6'b010000;
`else
    exp_gv = 6'b000000;
`endif
    cpu_write = 0; cpu_address = 25'h00100; rd_base = 16'h2000;
    vid_address = 25'h40000; vid_num = 10'd2;
    cpu_req = 1; vid_req = 1;
    gv = '0; g = 0; prev = 0; n = 0;
    while (g < 6 && n < 400) begin
      tick(); n++;
      cur = read_request | write_request;
      if (cur && !prev) begin
        gv[g] = (access_address == 25'h40000);
        g++;
      end
      prev = cur;
    end
    cpu_req = 0; vid_req = 0;
    checks++;
    if (g != 6 || gv !== exp_gv) begin
      errors++;
      $display("FAIL guard_grants: count=%0d pattern=%b, need 6 %b", g, gv, exp_gv);
    end
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (outs_zero_ctl() !== 1'b1) begin
      errors++; $display("FAIL guard_quiesce: arbiter not idle after drop, need idle");
    end
  endtask

  function automatic bit outs_zero_ctl();
    return access_address == '0 && write_request == 1'b0 && read_request == 1'b0
        && cpu_ack == 1'b0 && vid_done == 1'b0 && idle == 1'b1;
  endfunction

  task automatic test_reset_mid();
    int n, dn;
    vid_address = 25'h40000; vid_num = 10'd8; rd_base = 16'h1000; vid_req = 1;
    n = 0;
    while (vid_data_valid !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (vid_data_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_xfer: valid=%b need 1", vid_data_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (outs_zero() !== 1'b1) begin
      errors++; $display("FAIL rst_mid_zero: got nonzero outputs, need all 0");
    end
    vid_req = 0;
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (vid_done === 1'b1 || cpu_ack === 1'b1) dn++;
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (vid_done === 1'b1 || cpu_ack === 1'b1 || vid_data_valid === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++; $display("FAIL rst_mid_no_done: stray pulses=%0d need 0", dn);
    end
    cpu_write = 0; cpu_address = 25'h00042; rd_base = 16'h0777; cpu_req = 1;
    n = 0;
    while (cpu_ack !== 1'b1 && n < 30) begin tick(); n++; end
    checks++;
    if (cpu_ack !== 1'b1 || cpu_data_out !== 16'h0777) begin
      errors++;
      $display("FAIL rst_after_read: ack=%b data=%h, need 1 0777", cpu_ack, cpu_data_out);
    end
    cpu_req = 0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_video(10'd8, 8);
    test_video(10'd0, 1);
    test_both();
    test_guard();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
